// File: rtl/spi_pkg.sv
// Shared types and helpers for the burst-capable SPI slave.
package spi_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_state_t;

  localparam logic IDLE_FILL_DEFAULT = 1'b1;
  localparam int   DEFAULT_WIDTH     = 8;

  // Counter width for a WIDTH-bit word; never narrower than one bit.
  function automatic int spi_cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

  localparam int DEFAULT_CNT_W = spi_cnt_width(DEFAULT_WIDTH);

  // Maps the serial bit position within a word to the data-word bit index.
  function automatic int spi_bit_index(input int pos, input int width, input bit lsb_first);
    return lsb_first ? pos : (width - 1 - pos);
  endfunction

endpackage

// File: rtl/spi_bit_counter.sv
// Modulo-WIDTH bit counter for the SPI slave; flags the first and last bit of each word.
module spi_bit_counter
  import spi_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = spi_cnt_width(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_word_start,
  output logic             o_word_end
);

  logic [CNT_W-1:0] r_cnt;

  assign o_cnt        = r_cnt;
  assign o_word_start = (r_cnt == '0);
  assign o_word_end   = (r_cnt == CNT_W'(WIDTH - 1));

  // Wraps straight from the last bit to zero so bursts need no gap edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (o_word_end) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_slave_burst.sv
// Full-duplex SPI slave in the sclk domain: multi-word bursts, double-buffered
// transmit with valid/ready, per-word receive strobe and sticky underrun flag.
module spi_slave_burst
  import spi_pkg::*;
#(
  parameter int   WIDTH     = 8,
  parameter bit   LSB_FIRST = 1'b1,
  parameter logic IDLE_FILL = IDLE_FILL_DEFAULT
) (
  input  logic             sclk,
  input  logic             reset_n,
  input  logic             ss,
  input  logic             mosi,
  output logic             miso,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             busy,
  output logic             tx_underrun,
  input  logic             clear_flags
);

  localparam int CNT_W = spi_cnt_width(WIDTH);

  spi_state_t       r_state;
  logic [WIDTH-1:0] r_hold;
  logic             r_hold_full;
  logic [WIDTH-1:0] r_tx_shift;
  logic [WIDTH-1:0] r_rx_shift;
  logic [WIDTH-1:0] r_rx_data;
  logic             r_rx_valid;
  logic             r_miso;
  logic             r_underrun;

  logic [CNT_W-1:0] w_bit_cnt;
  logic             w_word_start;
  logic             w_word_end;
  logic             w_load;
  logic             w_accept;
  logic [CNT_W-1:0] w_idx;
  logic [WIDTH-1:0] w_word;
  logic [WIDTH-1:0] w_tx_src;
  logic [WIDTH-1:0] w_rx_next;

  spi_bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .i_clk        (sclk),
    .i_rst_n      (reset_n),
    .i_clear      (ss),
    .o_cnt        (w_bit_cnt),
    .o_word_start (w_word_start),
    .o_word_end   (w_word_end)
  );

  assign w_load   = ~ss & w_word_start;
  assign w_accept = tx_valid & ~r_hold_full;
  assign w_idx    = CNT_W'(spi_bit_index(int'(w_bit_cnt), WIDTH, LSB_FIRST));
  assign w_word   = r_hold_full ? r_hold : {WIDTH{IDLE_FILL}};
  // On a word-start edge the first bit comes from the word being loaded, not the stale shift register.
  assign w_tx_src = w_load ? w_word : r_tx_shift;

  // Received word including the bit sampled on this edge.
  always_comb begin
    w_rx_next        = r_rx_shift;
    w_rx_next[w_idx] = mosi;
  end

  assign miso        = r_miso;
  assign tx_ready    = ~r_hold_full;
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign busy        = (r_state == SHIFT);
  assign tx_underrun = r_underrun;

  // Frame FSM plus transmit/receive datapath and holding-register handshake.
  always_ff @(posedge sclk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_tx_shift  <= '0;
      r_rx_shift  <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_miso      <= IDLE_FILL;
      r_underrun  <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;

      case (r_state)
        IDLE:    r_state <= ss ? IDLE : SHIFT;
        SHIFT:   r_state <= ss ? IDLE : SHIFT;
        default: r_state <= IDLE;
      endcase

      if (ss) begin
        r_miso     <= IDLE_FILL;
        r_rx_shift <= '0;
      end else begin
        r_miso <= w_tx_src[w_idx];
        if (w_load) begin
          r_tx_shift <= w_word;
        end
        if (w_word_end) begin
          r_rx_data  <= w_rx_next;
          r_rx_valid <= 1'b1;
          r_rx_shift <= '0;
        end else begin
          r_rx_shift <= w_rx_next;
        end
      end

      // A consume and a fresh accept on one edge leave the holding register full.
      if (w_accept) begin
        r_hold <= tx_data;
      end
      r_hold_full <= (r_hold_full & ~w_load) | w_accept;

      if (w_load && !r_hold_full) begin
        r_underrun <= 1'b1;
      end else if (clear_flags) begin
        r_underrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_burst.sv
// Directed bench for spi_slave_burst: 8-bit LSB-first instance and 12-bit MSB-first instance.
module tb_spi_slave_burst;

  logic        sclk;
  logic        reset_n;
  logic        ss, mosi, miso, tx_valid, tx_ready, rx_valid, busy, tx_underrun, clear_flags;
  logic [7:0]  tx_data, rx_data;
  logic        ss2, mosi2, miso2, tx_valid2, tx_ready2, rx_valid2, busy2, tx_underrun2, clear_flags2;
  logic [11:0] tx_data2, rx_data2;

  int checks;
  int failures;

  spi_slave_burst #(.WIDTH(8), .LSB_FIRST(1'b1), .IDLE_FILL(1'b1)) dut (
    .sclk(sclk), .reset_n(reset_n), .ss(ss), .mosi(mosi), .miso(miso),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
    .tx_underrun(tx_underrun), .clear_flags(clear_flags)
  );

  spi_slave_burst #(.WIDTH(12), .LSB_FIRST(1'b0), .IDLE_FILL(1'b1)) dut_msb (
    .sclk(sclk), .reset_n(reset_n), .ss(ss2), .mosi(mosi2), .miso(miso2),
    .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ready(tx_ready2),
    .rx_data(rx_data2), .rx_valid(rx_valid2), .busy(busy2),
    .tx_underrun(tx_underrun2), .clear_flags(clear_flags2)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  // Inputs change on the falling edge; outputs are observed there too.
  task automatic tick();
    @(posedge sclk);
    @(negedge sclk);
  endtask

  task automatic load_hold(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    checks += 7;
    if (miso !== 1'b1) begin failures++; $display("FAIL reset_miso got=%b exp=1", miso); end
    if (tx_ready !== 1'b1) begin failures++; $display("FAIL reset_tx_ready got=%b exp=1", tx_ready); end
    if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (tx_underrun !== 1'b0) begin failures++; $display("FAIL reset_underrun got=%b exp=0", tx_underrun); end
    if (rx_data !== 8'h00) begin failures++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
    if (miso2 !== 1'b1) begin failures++; $display("FAIL reset_miso2 got=%b exp=1", miso2); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single_word();
    logic [7:0] txw;
    logic [7:0] rxw;
    logic       exp_v;
    txw = 8'hA5;
    rxw = 8'h3C;
    load_hold(txw);
    checks++;
    if (tx_ready !== 1'b0) begin failures++; $display("FAIL single_loaded_ready got=%b exp=0", tx_ready); end
    ss = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mosi = rxw[i];
      tick();
      exp_v = (i == 7) ? 1'b1 : 1'b0;
      checks += 3;
      if (miso !== txw[i]) begin failures++; $display("FAIL single_miso bit=%0d got=%b exp=%b", i, miso, txw[i]); end
      if (rx_valid !== exp_v) begin failures++; $display("FAIL single_rx_valid edge=%0d got=%b exp=%b", i, rx_valid, exp_v); end
      if (busy !== 1'b1) begin failures++; $display("FAIL single_busy edge=%0d got=%b exp=1", i, busy); end
    end
    checks++;
    if (rx_data !== 8'h3C) begin failures++; $display("FAIL single_rx_data got=%h exp=3c", rx_data); end
    ss   = 1'b1;
    mosi = 1'b0;
    tick();
    checks += 5;
    if (rx_valid !== 1'b0) begin failures++; $display("FAIL single_pulse_len got=%b exp=0", rx_valid); end
    if (busy !== 1'b0) begin failures++; $display("FAIL single_idle_busy got=%b exp=0", busy); end
    if (miso !== 1'b1) begin failures++; $display("FAIL single_idle_miso got=%b exp=1", miso); end
    if (tx_ready !== 1'b1) begin failures++; $display("FAIL single_consumed_ready got=%b exp=1", tx_ready); end
    if (tx_underrun !== 1'b0) begin failures++; $display("FAIL single_underrun got=%b exp=0", tx_underrun); end
  endtask

  task automatic test_burst();
    logic [7:0] txw [3];
    logic [7:0] rxw [3];
    logic [7:0] cur_tx;
    logic [7:0] cur_rx;
    logic       exp_v;
    int         pulses;
    txw[0] = 8'hA5; txw[1] = 8'h11; txw[2] = 8'h22;
    rxw[0] = 8'h5A; rxw[1] = 8'hC3; rxw[2] = 8'h96;
    pulses = 0;
    load_hold(txw[0]);
    ss = 1'b0;
    for (int i = 0; i < 24; i++) begin
      cur_tx = txw[i / 8];
      cur_rx = rxw[i / 8];
      mosi = cur_rx[i % 8];
      tx_valid = (i == 1 || i == 10) ? 1'b1 : 1'b0;
      tx_data  = (i == 1) ? 8'h11 : 8'h22;
      tick();
      tx_valid = 1'b0;
      exp_v = ((i % 8) == 7) ? 1'b1 : 1'b0;
      if (rx_valid === 1'b1) pulses++;
      checks += 2;
      if (miso !== cur_tx[i % 8]) begin failures++; $display("FAIL burst_miso edge=%0d got=%b exp=%b", i, miso, cur_tx[i % 8]); end
      if (rx_valid !== exp_v) begin failures++; $display("FAIL burst_rx_valid edge=%0d got=%b exp=%b", i, rx_valid, exp_v); end
      if (exp_v == 1'b1) begin
        checks++;
        if (rx_data !== cur_rx) begin failures++; $display("FAIL burst_rx_data edge=%0d got=%h exp=%h", i, rx_data, cur_rx); end
      end
    end
    ss = 1'b1;
    mosi = 1'b0;
    tick();
    checks += 2;
    if (pulses != 3) begin failures++; $display("FAIL burst_pulse_count got=%0d exp=3", pulses); end
    if (tx_underrun !== 1'b0) begin failures++; $display("FAIL burst_underrun got=%b exp=0", tx_underrun); end
  endtask

  task automatic test_underrun();
    logic [7:0] txw [4];
    logic [7:0] cur_tx;
    logic       exp_u;
    txw[0] = 8'h0F; txw[1] = 8'hFF; txw[2] = 8'hFF; txw[3] = 8'h3A;
    load_hold(txw[0]);
    ss = 1'b0;
    mosi = 1'b0;
    for (int i = 0; i < 32; i++) begin
      cur_tx = txw[i / 8];
      tx_valid    = (i == 16) ? 1'b1 : 1'b0;
      tx_data     = 8'h3A;
      clear_flags = (i == 16 || i == 20) ? 1'b1 : 1'b0;
      tick();
      tx_valid    = 1'b0;
      clear_flags = 1'b0;
      exp_u = (i >= 8 && i < 20) ? 1'b1 : 1'b0;
      checks += 2;
      if (miso !== cur_tx[i % 8]) begin failures++; $display("FAIL underrun_miso edge=%0d got=%b exp=%b", i, miso, cur_tx[i % 8]); end
      if (tx_underrun !== exp_u) begin failures++; $display("FAIL underrun_flag edge=%0d got=%b exp=%b", i, tx_underrun, exp_u); end
      if (i == 16) begin
        checks++;
        if (tx_ready !== 1'b0) begin failures++; $display("FAIL underrun_reload_ready got=%b exp=0", tx_ready); end
      end
    end
    ss = 1'b1;
    tick();
  endtask

  task automatic test_abort();
    logic [7:0] txa;
    logic [7:0] txb;
    logic [7:0] rxb;
    logic       exp_v;
    txa = 8'hC6;
    txb = 8'h96;
    rxb = 8'h81;
    load_hold(txa);
    ss = 1'b0;
    mosi = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tx_valid = (i == 2) ? 1'b1 : 1'b0;
      tx_data  = txb;
      tick();
      tx_valid = 1'b0;
      checks += 2;
      if (miso !== txa[i]) begin failures++; $display("FAIL abort_miso edge=%0d got=%b exp=%b", i, miso, txa[i]); end
      if (rx_valid !== 1'b0) begin failures++; $display("FAIL abort_partial_valid edge=%0d got=%b exp=0", i, rx_valid); end
    end
    ss = 1'b1;
    tick();
    checks += 4;
    if (rx_valid !== 1'b0) begin failures++; $display("FAIL abort_rx_valid got=%b exp=0", rx_valid); end
    if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
    if (miso !== 1'b1) begin failures++; $display("FAIL abort_miso_idle got=%b exp=1", miso); end
    if (tx_ready !== 1'b0) begin failures++; $display("FAIL abort_hold_kept got=%b exp=0", tx_ready); end
    ss = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mosi = rxb[i];
      tick();
      exp_v = (i == 7) ? 1'b1 : 1'b0;
      checks += 2;
      if (miso !== txb[i]) begin failures++; $display("FAIL restart_miso bit=%0d got=%b exp=%b", i, miso, txb[i]); end
      if (rx_valid !== exp_v) begin failures++; $display("FAIL restart_rx_valid edge=%0d got=%b exp=%b", i, rx_valid, exp_v); end
    end
    checks++;
    if (rx_data !== 8'h81) begin failures++; $display("FAIL restart_rx_data got=%h exp=81", rx_data); end
    ss = 1'b1;
    mosi = 1'b0;
    tick();
  endtask

  task automatic test_reset_midword();
    ss = 1'b0;
    tick();
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    checks += 6;
    if (miso !== 1'b1) begin failures++; $display("FAIL midreset_miso got=%b exp=1", miso); end
    if (busy !== 1'b0) begin failures++; $display("FAIL midreset_busy got=%b exp=0", busy); end
    if (tx_ready !== 1'b1) begin failures++; $display("FAIL midreset_tx_ready got=%b exp=1", tx_ready); end
    if (rx_data !== 8'h00) begin failures++; $display("FAIL midreset_rx_data got=%h exp=00", rx_data); end
    if (rx_valid !== 1'b0) begin failures++; $display("FAIL midreset_rx_valid got=%b exp=0", rx_valid); end
    if (tx_underrun !== 1'b0) begin failures++; $display("FAIL midreset_underrun got=%b exp=0", tx_underrun); end
    ss = 1'b1;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_msb_first();
    logic [11:0] txw;
    logic [11:0] rxw;
    logic        exp_v;
    txw = 12'h801;
    rxw = 12'hABC;
    tx_data2  = txw;
    tx_valid2 = 1'b1;
    tick();
    tx_valid2 = 1'b0;
    ss2 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      mosi2 = rxw[11 - i];
      tick();
      exp_v = (i == 11) ? 1'b1 : 1'b0;
      checks += 2;
      if (miso2 !== txw[11 - i]) begin failures++; $display("FAIL msb_miso edge=%0d got=%b exp=%b", i, miso2, txw[11 - i]); end
      if (rx_valid2 !== exp_v) begin failures++; $display("FAIL msb_rx_valid edge=%0d got=%b exp=%b", i, rx_valid2, exp_v); end
    end
    checks++;
    if (rx_data2 !== 12'hABC) begin failures++; $display("FAIL msb_rx_data got=%h exp=abc", rx_data2); end
    ss2 = 1'b1;
    mosi2 = 1'b0;
    tick();
    checks += 2;
    if (busy2 !== 1'b0) begin failures++; $display("FAIL msb_busy got=%b exp=0", busy2); end
    if (tx_underrun2 !== 1'b0) begin failures++; $display("FAIL msb_underrun got=%b exp=0", tx_underrun2); end
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    reset_n      = 1'b0;
    ss           = 1'b1;
    mosi         = 1'b0;
    tx_data      = 8'h00;
    tx_valid     = 1'b0;
    clear_flags  = 1'b0;
    ss2          = 1'b1;
    mosi2        = 1'b0;
    tx_data2     = 12'h000;
    tx_valid2    = 1'b0;
    clear_flags2 = 1'b0;

    test_reset();
    test_single_word();
    test_burst();
    test_underrun();
    test_abort();
    test_reset_midword();
    test_msb_first();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
